// File: rtl/cbus_arbiter.sv
`timescale 1ns/1ps
// cbus_arbiter: shares the memory-side cbus among cache requesters, holding each grant for a whole burst.
// Define CBUS_ARB_RR_EN for round-robin arbitration; default is fixed priority (highest index wins).
// Flat port layout, MSB first. req: valid, is_write, size[2:0], addr[31:0], strobe[3:0], data[31:0], len[3:0].
// resp: ready, last, data[31:0].
module cbus_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int REQ_W   = 77,
  localparam int RESP_W  = 34
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*REQ_W-1:0]  ireqs,
  output logic [NUM_REQ*RESP_W-1:0] iresps,
  output logic [REQ_W-1:0]          oreq,
  input  logic [RESP_W-1:0]         oresp,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      err
);

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [4:0]       beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  cbus_req_t        req_a [NUM_REQ];
  cbus_req_t        greq;
  logic [NUM_REQ-1:0] req_valid;
  logic             any_valid;
  logic [IDX_W-1:0] winner;
  logic             rsp_ready;
  logic             rsp_last;
  logic [4:0]       beat_next;
  logic [4:0]       beats_exp;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_a[i]     = ireqs[i*REQ_W +: REQ_W];
      req_valid[i] = req_a[i].valid;
    end
    any_valid = |req_valid;
  end

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] last_winner_q, last_winner_d;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int unsigned      cand;

  // Search starts one past the previous winner and wraps, so every requester is reached within NUM_REQ grants.
  always_comb begin
    winner   = last_winner_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_winner_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (state_q == IDLE && any_valid) begin
      last_winner_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        winner = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    greq        = req_a[grant_idx_q];
    rsp_ready   = oresp[RESP_W-1];
    rsp_last    = oresp[RESP_W-2];
    beat_next   = beat_cnt_q + 5'd1;
    beats_exp   = {1'b0, greq.len} + 5'd1;
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    oreq        = '0;
    iresps      = '0;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (any_valid) begin
          grant_idx_d = winner;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Passthrough also forwards a dropped valid, so an abort reaches the bridge as oreq.valid = 0.
        oreq = greq;
        iresps[int'(grant_idx_q)*RESP_W +: RESP_W] = oresp;
        if (!greq.valid) begin
          err_d      = 1'b1;
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (rsp_ready) begin
          beat_cnt_d = beat_next;
          if (rsp_last || beat_next == beats_exp) begin
            if (!(rsp_last && beat_next == beats_exp)) begin
              err_d = 1'b1;
            end
            state_d    = IDLE;
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign grant_idx = grant_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for cbus_arbiter: stimulus pushes expected beats to a scoreboard, a monitor checks them.
module tb_cbus_arbiter;
  localparam int N      = 2;
  localparam int IDX_W  = 1;
  localparam int REQ_W  = 77;
  localparam int RESP_W = 34;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } req_t;

  typedef struct {
    int                idx;
    logic [RESP_W-1:0] rsp;
    req_t              req;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N*REQ_W-1:0]    ireqs;
  logic [N*RESP_W-1:0]   iresps;
  logic [REQ_W-1:0]      oreq;
  logic [RESP_W-1:0]     oresp;
  logic                  busy;
  logic [IDX_W-1:0]      grant_idx;
  logic                  err;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  req_t preq [N];
  bit   pend [N];
  bit   err_exp;
`ifdef CBUS_ARB_RR_EN
  int   lw;
`endif

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t rand_req();
    req_t        r;
    int unsigned lens [4];
    lens       = '{0, 1, 3, 7};
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.size     = 3'd2;
    r.addr     = $urandom() & 32'hFFFF_FFFC;
    r.strobe   = 4'($urandom());
    r.data     = $urandom();
    r.len      = 4'(lens[$urandom_range(0, 3)]);
    return r;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      ireqs[i*REQ_W +: REQ_W] = pend[i] ? preq[i] : '0;
    end
  endtask

  // Reference arbitration: fixed = highest pending index; round-robin = first pending after the last winner.
  function automatic int pick_winner();
`ifdef CBUS_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (pend[(lw + k) % N]) return (lw + k) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic repend_random();
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) begin
        preq[i] = rand_req();
        pend[i] = 1;
      end
      any = any | pend[i];
    end
    if (!any) begin
      preq[0] = rand_req();
      pend[0] = 1;
    end
    drive_reqs();
  endtask

  // mode 0 normal, 1 early last, 2 no last, 3 requester abort
  task automatic run_burst(input int mode_in);
    int          w, nb, beats, mode;
    req_t        r;
    exp_t        e;
    logic [31:0] d;
    logic        lst;
    mode = mode_in;
    w    = pick_winner();
`ifdef CBUS_ARB_RR_EN
    lw = w;
`endif
    tick();
    chk("grant_idx", 128'(grant_idx), 128'(w));
    chk("busy_grant", 128'(busy), 128'(1));
    r  = preq[w];
    nb = int'(r.len) + 1;
    if (mode == 1 && nb == 1) mode = 0;
    case (mode)
      1:       beats = $urandom_range(1, nb - 1);
      3:       beats = $urandom_range(0, nb - 1);
      default: beats = nb;
    endcase
    for (int b = 1; b <= beats; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      d     = $urandom();
      lst   = (b == beats) && (mode == 0 || mode == 1);
      e.idx = w;
      e.rsp = {1'b1, lst, d};
      e.req = r;
      sbq.push_back(e);
      oresp = {1'b1, lst, d};
      tick();
      oresp = '0;
    end
    pend[w] = 0;
    if (mode == 3) begin
      drive_reqs();
      @(negedge clk);
      chk("abort_oreq_valid", 128'(oreq[REQ_W-1]), 128'(0));
      tick();
    end
    if (mode != 0) err_exp = 1;
    chk("busy_end", 128'(busy), 128'(0));
    chk("err_end", 128'(err), 128'(err_exp));
    drive_reqs();
  endtask

  logic [N*RESP_W-1:0] mon_exp;
  exp_t                mon_e;
  bit                  mon_any;

  initial begin
    forever begin
      @(negedge clk);
      mon_any = 0;
      for (int i = 0; i < N; i++) begin
        if (iresps[i*RESP_W + RESP_W - 1]) mon_any = 1;
      end
      if (mon_any) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got %0h expected no response", iresps);
        end else begin
          mon_e   = sbq.pop_front();
          mon_exp = '0;
          mon_exp[mon_e.idx*RESP_W +: RESP_W] = mon_e.rsp;
          if (iresps !== mon_exp) begin
            errors++;
            $display("FAIL beat_resp: got %0h expected %0h", iresps, mon_exp);
          end
          checks++;
          if (oreq !== mon_e.req) begin
            errors++;
            $display("FAIL beat_oreq: got %0h expected %0h", oreq, mon_e.req);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   w;
    exp_t e;
    reset   = 1'b1;
    ireqs   = '0;
    oresp   = '0;
    err_exp = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
`ifdef CBUS_ARB_RR_EN
    lw = N - 1;
`endif
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_idx), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresps", 128'(iresps), 128'(0));
    tick();

    // ICache MLEN4 read
    preq[0] = '{valid: 1'b1, is_write: 1'b0, size: 3'd2, addr: 32'h8000_0010,
                strobe: 4'h0, data: 32'h0, len: 4'd3};
    pend[0] = 1;
    drive_reqs();
    run_burst(0);

    // simultaneous ICache read and DCache MLEN1 write
    preq[0] = rand_req();
    preq[0].is_write = 1'b0;
    preq[1] = '{valid: 1'b1, is_write: 1'b1, size: 3'd2, addr: 32'h8000_0100,
                strobe: 4'hF, data: 32'hDEAD_BEEF, len: 4'd0};
    pend[0] = 1;
    pend[1] = 1;
    drive_reqs();
    run_burst(0);
    run_burst(0);

    // both requesters held valid over four bursts
    for (int i = 0; i < N; i++) begin
      preq[i] = rand_req();
      pend[i] = 1;
    end
    drive_reqs();
    for (int n = 0; n < 4; n++) begin
      run_burst(0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          preq[i] = rand_req();
          pend[i] = 1;
        end
      end
      drive_reqs();
    end

    // early last on an MLEN4 burst, then a normal burst with err held
    w = pick_winner();
    preq[w].len = 4'd3;
    drive_reqs();
    run_burst(1);
    run_burst(0);

    // abort mid-burst
    repend_random();
    w = pick_winner();
    preq[w].len = 4'd3;
    drive_reqs();
    run_burst(3);

    for (int n = 0; n < 60; n++) begin
      repend_random();
      run_burst(($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
    end

    // reset on beat 2 of an MLEN4 burst
    repend_random();
    w = pick_winner();
    preq[w].len = 4'd3;
    drive_reqs();
    tick();
    chk("rstmid_grant", 128'(grant_idx), 128'(w));
    e.idx = w;
    e.rsp = {1'b1, 1'b0, 32'h1234_5678};
    e.req = preq[w];
    sbq.push_back(e);
    oresp = {1'b1, 1'b0, 32'h1234_5678};
    tick();
    oresp = '0;
    reset = 1'b1;
    tick();
    chk("rstmid_busy", 128'(busy), 128'(0));
    chk("rstmid_grant0", 128'(grant_idx), 128'(0));
    chk("rstmid_err", 128'(err), 128'(0));
    chk("rstmid_oreq_valid", 128'(oreq[REQ_W-1]), 128'(0));
    reset = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    drive_reqs();
    tick();
    chk("sb_drain", 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
